// File: rtl/alu_control_mdu.sv
// alu_control_mdu: ALU select decode plus an iterative multiply/divide unit.
// Ports:
//   Clk, Reset_n          clock, asynchronous active-low reset
//   Funct, ALUOp          instruction funct field and operation class
//   Start, A, B           MDU request and operands (captured on accept)
//   Saida, Break          combinational ALU select and BREAK flag
//   Busy, Done            MDU in progress, one-cycle completion pulse
//   Hi, Lo                MDU result registers
//   DivZero, Unimpl       sticky divide-by-zero flag, rejected-divide pulse
// Define ALU_CTRL_DIV_EN to build the divider; without it DIV/DIVU are rejected.
module alu_control_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [5:0]       Funct,
    input  logic [2:0]       ALUOp,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [2:0]       Saida,
    output logic             Break,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivZero,
    output logic             Unimpl
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t             state, start_state;
    logic [2*WIDTH-1:0] prod, mul_next, mul_res;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mb, mag_a, mag_b;
    logic [CNT_W-1:0]   cnt;
    logic               sa, sb, neg_a, neg_b, mdu_req, accept;

    assign Saida = ALUOp == 3'b000 ? 3'b001 :
                   ALUOp == 3'b001 ? 3'b010 :
                   ALUOp == 3'b011 ? 3'b110 :
                   ALUOp != 3'b010 ? 3'b000 :
                   (Funct == 6'h20 || Funct == 6'h21) ? 3'b001 :
                   (Funct == 6'h22 || Funct == 6'h23) ? 3'b010 :
                   Funct == 6'h24 ? 3'b011 :
                   Funct == 6'h26 ? 3'b110 : 3'b000;
    assign Break = ALUOp == 3'b010 && Funct == 6'h0D;

    // Funct 0x18..0x1B: bit1 selects divide, bit0 selects unsigned
    assign mdu_req = Start && ALUOp == 3'b010 && Funct[5:2] == 4'b0110;
    assign neg_a   = !Funct[0] && A[WIDTH-1];
    assign neg_b   = !Funct[0] && B[WIDTH-1];
    assign mag_a   = neg_a ? -A : A;
    assign mag_b   = neg_b ? -B : B;

    // Shift-add: multiplier sits in the low half and is consumed LSB first
    assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mb} : '0);
    assign mul_next = {mul_sum, prod[WIDTH-1:1]};
    assign mul_res  = (sa ^ sb) ? -prod : prod;

`ifdef ALU_CTRL_DIV_EN
    logic               op_div, div_ge;
    logic [WIDTH:0]     div_t;
    logic [WIDTH-1:0]   div_r, div_hi, div_lo;
    logic [2*WIDTH-1:0] div_next;
    assign accept      = mdu_req;
    assign start_state = !Funct[1] ? MUL : B == '0 ? FIX : DIV;
    // Restoring divide: prod = {remainder, dividend/quotient}
    assign div_t    = prod[2*WIDTH-1:WIDTH-1];
    assign div_ge   = div_t >= {1'b0, mb};
    assign div_r    = div_ge ? div_t[WIDTH-1:0] - mb : div_t[WIDTH-1:0];
    assign div_next = {div_r, prod[WIDTH-2:0], div_ge};
    // On divide-by-zero the low half still holds |A|, so A is rebuilt from it
    assign div_lo = DivZero ? '1 : (sa ^ sb) ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    assign div_hi = DivZero ? (sa ? -prod[WIDTH-1:0] : prod[WIDTH-1:0]) :
                    sa ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
`else
    assign accept      = mdu_req && !Funct[1];
    assign start_state = MUL;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            prod    <= '0;
            mb      <= '0;
            cnt     <= '0;
            sa      <= 1'b0;
            sb      <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            DivZero <= 1'b0;
            Unimpl  <= 1'b0;
            Hi      <= '0;
            Lo      <= '0;
`ifdef ALU_CTRL_DIV_EN
            op_div  <= 1'b0;
`endif
        end else begin
            Done   <= 1'b0;
            Unimpl <= 1'b0;
            case (state)
                IDLE: begin
                    Busy   <= accept;
                    Unimpl <= mdu_req && !accept;
                    if (accept) begin
                        state   <= start_state;
                        prod    <= {{WIDTH{1'b0}}, mag_a};
                        mb      <= mag_b;
                        sa      <= neg_a;
                        sb      <= neg_b;
                        cnt     <= CNT_W'(WIDTH - 1);
                        DivZero <= Funct[1] && B == '0;
`ifdef ALU_CTRL_DIV_EN
                        op_div  <= Funct[1];
`endif
                    end
                end
                MUL: begin
                    prod <= mul_next;
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == '0) state <= FIX;
                end
`ifdef ALU_CTRL_DIV_EN
                DIV: begin
                    prod <= div_next;
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == '0) state <= FIX;
                end
`endif
                FIX: begin
                    Done  <= 1'b1;
                    state <= IDLE;
`ifdef ALU_CTRL_DIV_EN
                    {Hi, Lo} <= op_div ? {div_hi, div_lo} : mul_res;
`else
                    {Hi, Lo} <= mul_res;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_control_mdu.sv
// tb_alu_control_mdu: scoreboard bench for the ALU decode and multiply/divide unit.
module tb_alu_control_mdu;
    localparam int W = 32;
`ifdef ALU_CTRL_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           due;
    } exp_t;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [5:0]   funct = '0;
    logic [2:0]   aluop = '0;
    logic [W-1:0] a = '0, b = '0;
    logic [2:0]   saida;
    logic         brk, busy, done, dz, unimpl;
    logic [W-1:0] hi, lo;
    int           checks = 0, errors = 0, cyc = 0;
    exp_t         exp_q[$];
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic         m_dz = 1'b0;

    alu_control_mdu #(.WIDTH(W)) dut (
        .Clk(clk), .Reset_n(rst_n), .Funct(funct), .ALUOp(aluop), .Start(start),
        .A(a), .B(b), .Saida(saida), .Break(brk), .Busy(busy), .Done(done),
        .Hi(hi), .Lo(lo), .DivZero(dz), .Unimpl(unimpl)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, want);
        end
    endtask

    function automatic logic [2:0] ref_saida(input logic [2:0] op, input logic [5:0] f);
        if (op == 3'd0) return 3'b001;
        if (op == 3'd1) return 3'b010;
        if (op == 3'd3) return 3'b110;
        if (op != 3'd2) return 3'b000;
        case (f)
            6'h20, 6'h21: return 3'b001;
            6'h22, 6'h23: return 3'b010;
            6'h24:        return 3'b011;
            6'h26:        return 3'b110;
            default:      return 3'b000;
        endcase
    endfunction

    // op[1]: divide, op[0]: unsigned
    function automatic void ref_mdu(input logic [1:0] op, input logic [W-1:0] x, y,
                                    output logic [W-1:0] h, output logic [W-1:0] l);
        logic [2*W-1:0] p;
        if (!op[1]) begin
            p = op[0] ? {{W{1'b0}}, x} * {{W{1'b0}}, y}
                      : {{W{x[W-1]}}, x} * {{W{y[W-1]}}, y};
            h = p[2*W-1:W];
            l = p[W-1:0];
        end else if (y == 0) begin
            h = x;
            l = '1;
        end else if (op[0]) begin
            l = x / y;
            h = x % y;
        end else if (x == {1'b1, {(W-1){1'b0}}} && y == '1) begin
            l = x;
            h = '0;
        end else begin
            l = $signed(x) / $signed(y);
            h = $signed(x) % $signed(y);
        end
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done) begin
            if (exp_q.size() == 0) check("spurious_done", 64'(done), 64'd0);
            else begin
                e = exp_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.due));
                check("hi", 64'(hi), 64'(e.hi));
                check("lo", 64'(lo), 64'(e.lo));
                check("divzero", 64'(dz), 64'(e.dz));
            end
        end
    end

    task automatic dec(input logic [2:0] op, input logic [5:0] f, input logic [2:0] s, input logic br);
        aluop = op;
        funct = f;
        #1;
        check("dec_saida", 64'(saida), 64'(s));
        check("dec_break", 64'(brk), 64'(br));
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge
    task automatic issue(input logic [5:0] f, input logic [W-1:0] x, y);
        exp_t e;
        logic [W-1:0] h, l;
        int n = 0;
        logic acc;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_wait", 64'(busy), 64'd0);
        aluop = 3'b010;
        funct = f;
        a = x;
        b = y;
        start = 1'b1;
        acc = !(f[1] && !DIV_EN);
        if (acc) begin
            ref_mdu(f[1:0], x, y, h, l);
            m_hi = h;
            m_lo = l;
            m_dz = f[1] && y == 0;
            e.hi = h;
            e.lo = l;
            e.dz = m_dz;
            e.due = cyc + 1 + (m_dz ? 1 : W + 1);
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        aluop = 3'($urandom);
        funct = 6'($urandom);
        a = $urandom;
        b = $urandom;
        if (acc) check("busy_on_accept", 64'(busy), 64'd1);
        else begin
            check("unimpl_pulse", 64'(unimpl), 64'd1);
            check("busy_rejected", 64'(busy), 64'd0);
            check("hi_held", 64'(hi), 64'(m_hi));
            check("lo_held", 64'(lo), 64'(m_lo));
            check("dz_held", 64'(dz), 64'(m_dz));
            @(negedge clk);
            check("unimpl_clear", 64'(unimpl), 64'd0);
        end
    endtask

    initial begin
        int n;
        logic [5:0] f;
        logic [W-1:0] x, y;
        repeat (2) @(negedge clk);
        check("rst_flags", 64'({busy, done, dz, unimpl}), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;
        dec(3'b010, 6'h21, 3'b001, 1'b0);
        dec(3'b010, 6'h26, 3'b110, 1'b0);
        dec(3'b010, 6'h0D, 3'b000, 1'b1);
        dec(3'b011, 6'($urandom), 3'b110, 1'b0);
        for (int i = 0; i < 60; i++) begin
            aluop = 3'($urandom);
            funct = (i % 3 == 0) ? 6'h20 + 6'($urandom_range(0, 7)) : 6'($urandom);
            #1;
            check("sweep_saida", 64'(saida), 64'(ref_saida(aluop, funct)));
            check("sweep_break", 64'(brk), 64'(aluop == 3'b010 && funct == 6'h0D));
        end
        @(negedge clk);
        issue(6'h18, 32'hFFFFFFFD, 32'd5);
        issue(6'h19, 32'hFFFFFFFD, 32'd5);
        issue(6'h1A, 32'hFFFFFFF9, 32'd2);
        issue(6'h1B, 32'd100, 32'd7);
        issue(6'h1B, 32'h1234, 32'd0);
        issue(6'h18, 32'd7, 32'd9);
        issue(6'h1A, 32'h80000000, 32'hFFFFFFFF);
        issue(6'h18, 32'h00012345, 32'hFFFF0001);
        repeat (4) @(negedge clk);
        aluop = 3'b010;
        funct = 6'h19;
        a = 32'h55555555;
        b = 32'h33333333;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_ignored_start", 64'(busy), 64'd1);
        issue(6'h19, 32'hDEADBEEF, 32'h01234567);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        m_hi = '0;
        m_lo = '0;
        m_dz = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_result", {hi, lo}, 64'd0);
        for (int i = 0; i < 40; i++) begin
            f = 6'h18 | 6'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 9))
                0: y = '0;
                1: begin x = 32'h80000000; y = '1; end
                2, 3: y = $urandom_range(1, 15);
                default: ;
            endcase
            issue(f, x, y);
        end
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
